// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of a single-port synchronous memory.
// One transaction in flight; ties alternate between ports.
module mem_arbiter #(
  parameter int AW = 12,
  parameter int DW = 32
) (
  input  logic          clk_cpu,
  input  logic          reset,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic [DW-1:0] m0_rdata,
  output logic          m0_ack,
  output logic          m0_stall,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic [DW-1:0] m1_rdata,
  output logic          m1_ack,
  output logic          m1_stall,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_din,
  input  logic [DW-1:0] mem_dout,
  output logic [1:0]    gnt,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, ACK} state_t;

  state_t        state_q, state_d;
  logic          owner_q, owner_d;   // 0: port 0 owns the memory, 1: port 1
  logic          last_q, last_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] din_q, din_d;
  logic [DW-1:0] rdata0_q, rdata0_d;
  logic [DW-1:0] rdata1_q, rdata1_d;
  logic          win;

  always_ff @(posedge clk_cpu or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      owner_q  <= 1'b0;
      last_q   <= 1'b1;
      we_q     <= 1'b0;
      addr_q   <= '0;
      din_q    <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      din_q    <= din_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    last_d   = last_q;
    we_d     = we_q;
    addr_d   = addr_q;
    din_d    = din_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    win      = 1'b0;
    case (state_q)
      IDLE: begin
        if (m0_req || m1_req) begin
          // On a tie the port that did not win last time goes first.
          win     = (m0_req && m1_req) ? ~last_q : m1_req;
          owner_d = win;
          last_d  = win;
          we_d    = win ? m1_we    : m0_we;
          addr_d  = win ? m1_addr  : m0_addr;
          din_d   = win ? m1_wdata : m0_wdata;
          state_d = ACCESS;
        end
      end
      ACCESS: state_d = we_q ? ACK : WAIT;
      WAIT: begin
        if (owner_q) rdata1_d = mem_dout;
        else         rdata0_d = mem_dout;
        state_d = ACK;
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign mem_we   = (state_q == ACCESS) && we_q;
  assign mem_addr = addr_q;
  assign mem_din  = din_q;
  assign busy     = (state_q != IDLE);
  assign gnt      = (state_q == IDLE) ? 2'b00 : (owner_q ? 2'b10 : 2'b01);
  assign m0_ack   = (state_q == ACK) && !owner_q;
  assign m1_ack   = (state_q == ACK) && owner_q;
  assign m0_stall = m0_req && !m0_ack;
  assign m1_stall = m1_req && !m1_ack;
  assign m0_rdata = rdata0_q;
  assign m1_rdata = rdata1_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a synchronous memory model plus a transaction-level
// reference that plans grant order and ack cycles from the arbitration rules.
module tb_mem_arbiter;
  localparam int AW = 12;
  localparam int DW = 32;

  logic          clk_cpu = 1'b0;
  logic          reset = 1'b1;
  logic          m0_req = 1'b0, m0_we = 1'b0;
  logic [AW-1:0] m0_addr = '0;
  logic [DW-1:0] m0_wdata = '0;
  logic [DW-1:0] m0_rdata;
  logic          m0_ack, m0_stall;
  logic          m1_req = 1'b0, m1_we = 1'b0;
  logic [AW-1:0] m1_addr = '0;
  logic [DW-1:0] m1_wdata = '0;
  logic [DW-1:0] m1_rdata;
  logic          m1_ack, m1_stall;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din;
  logic [DW-1:0] mem_dout;
  logic [1:0]    gnt;
  logic          busy;

  mem_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk_cpu(clk_cpu), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_rdata(m0_rdata), .m0_ack(m0_ack), .m0_stall(m0_stall),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_rdata(m1_rdata), .m1_ack(m1_ack), .m1_stall(m1_stall),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout),
    .gnt(gnt), .busy(busy)
  );

  always #5 clk_cpu = ~clk_cpu;

  // Single-port synchronous memory: data appears the cycle after the address.
  logic [DW-1:0] mem [0:4095];
  always @(posedge clk_cpu) begin
    if (mem_we) mem[mem_addr] <= mem_din;
    mem_dout <= mem[mem_addr];
  end

  int n_cmp = 0;
  int n_err = 0;

  logic [DW-1:0] ref_mem [0:4095];
  logic [DW-1:0] rd_ref [0:1];
  bit            last_ref;
  logic [AW-1:0] addr_ref;
  logic [DW-1:0] din_ref;

  int            nq [0:1];
  bit            qwe [0:1][0:11];
  logic [AW-1:0] qa  [0:1][0:11];
  logic [DW-1:0] qd  [0:1][0:11];

  task automatic drive(input int p, input bit req, input bit we,
                       input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (p == 0) begin m0_req = req; m0_we = we; m0_addr = a; m0_wdata = d; end
    else        begin m1_req = req; m1_we = we; m1_addr = a; m1_wdata = d; end
  endtask

  task automatic clear_q();
    nq[0] = 0;
    nq[1] = 0;
  endtask

  task automatic push(input int p, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    qwe[p][nq[p]] = we;
    qa[p][nq[p]]  = a;
    qd[p][nq[p]]  = d;
    nq[p]++;
  endtask

  // Each port works through its own queue, holding req until ack and raising
  // the next request in its ack cycle. mode 1: the first winner's inputs are
  // scrambled in ACCESS; mode 2: additionally its req is dropped before ack.
  task automatic run_scenario(input int mode);
    int ntx, t, p, last;
    int sp [0:23];
    int sk [0:23];
    int ss [0:23];
    int sa [0:23];
    int idx [0:1];
    int cur [0:1];
    bit lg, e_busy, e_we;
    bit [1:0] e_gnt, e_ack;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_din;
    ntx = 0; t = 0; lg = last_ref; idx[0] = 0; idx[1] = 0;
    while (idx[0] < nq[0] || idx[1] < nq[1]) begin
      if (idx[0] < nq[0] && idx[1] < nq[1]) p = lg ? 0 : 1;
      else p = (idx[0] < nq[0]) ? 0 : 1;
      sp[ntx] = p; sk[ntx] = idx[p]; ss[ntx] = t;
      sa[ntx] = t + (qwe[p][idx[p]] ? 2 : 3);
      t = sa[ntx] + 1;
      idx[p]++;
      lg = (p == 1);
      ntx++;
    end
    last = sa[ntx-1];
    @(negedge clk_cpu);
    for (int q = 0; q < 2; q++) begin
      cur[q] = 0;
      if (nq[q] > 0) drive(q, 1'b1, qwe[q][0], qa[q][0], qd[q][0]);
    end
    for (int c = 1; c <= last; c++) begin
      @(negedge clk_cpu);
      e_busy = 1'b0; e_we = 1'b0; e_gnt = 2'b00; e_ack = 2'b00;
      e_addr = addr_ref; e_din = din_ref;
      for (int i = 0; i < ntx; i++) begin
        if (c > ss[i]) begin
          e_addr = qa[sp[i]][sk[i]];
          e_din  = qd[sp[i]][sk[i]];
        end
        if (c > ss[i] && c <= sa[i]) begin
          e_busy = 1'b1;
          e_gnt  = (sp[i] == 1) ? 2'b10 : 2'b01;
        end
        if (c == ss[i] + 1 && qwe[sp[i]][sk[i]]) e_we = 1'b1;
        if (c == sa[i]) begin
          e_ack[sp[i]] = 1'b1;
          if (qwe[sp[i]][sk[i]]) ref_mem[qa[sp[i]][sk[i]]] = qd[sp[i]][sk[i]];
          else rd_ref[sp[i]] = ref_mem[qa[sp[i]][sk[i]]];
        end
      end
      n_cmp++; if (m0_ack !== e_ack[0]) begin n_err++; $display("FAIL m0_ack cyc %0d: got %b expected %b", c, m0_ack, e_ack[0]); end
      n_cmp++; if (m1_ack !== e_ack[1]) begin n_err++; $display("FAIL m1_ack cyc %0d: got %b expected %b", c, m1_ack, e_ack[1]); end
      n_cmp++; if (gnt !== e_gnt) begin n_err++; $display("FAIL gnt cyc %0d: got %b expected %b", c, gnt, e_gnt); end
      n_cmp++; if (busy !== e_busy) begin n_err++; $display("FAIL busy cyc %0d: got %b expected %b", c, busy, e_busy); end
      n_cmp++; if (mem_we !== e_we) begin n_err++; $display("FAIL mem_we cyc %0d: got %b expected %b", c, mem_we, e_we); end
      n_cmp++; if (mem_addr !== e_addr) begin n_err++; $display("FAIL mem_addr cyc %0d: got %h expected %h", c, mem_addr, e_addr); end
      n_cmp++; if (mem_din !== e_din) begin n_err++; $display("FAIL mem_din cyc %0d: got %h expected %h", c, mem_din, e_din); end
      n_cmp++; if (m0_rdata !== rd_ref[0]) begin n_err++; $display("FAIL m0_rdata cyc %0d: got %h expected %h", c, m0_rdata, rd_ref[0]); end
      n_cmp++; if (m1_rdata !== rd_ref[1]) begin n_err++; $display("FAIL m1_rdata cyc %0d: got %h expected %h", c, m1_rdata, rd_ref[1]); end
      n_cmp++; if (m0_stall !== (m0_req & ~e_ack[0])) begin n_err++; $display("FAIL m0_stall cyc %0d: got %b expected %b", c, m0_stall, m0_req & ~e_ack[0]); end
      n_cmp++; if (m1_stall !== (m1_req & ~e_ack[1])) begin n_err++; $display("FAIL m1_stall cyc %0d: got %b expected %b", c, m1_stall, m1_req & ~e_ack[1]); end
      for (int q = 0; q < 2; q++) begin
        if (e_ack[q]) begin
          cur[q]++;
          if (cur[q] < nq[q]) drive(q, 1'b1, qwe[q][cur[q]], qa[q][cur[q]], qd[q][cur[q]]);
          else drive(q, 1'b0, 1'b0, '0, '0);
        end
      end
      if (mode != 0 && c == 1) begin
        p = sp[0];
        drive(p, mode == 1, ~qwe[p][0], qa[p][0] ^ 12'h010, $urandom);
      end
    end
    last_ref = lg;
    addr_ref = qa[sp[ntx-1]][sk[ntx-1]];
    din_ref  = qd[sp[ntx-1]][sk[ntx-1]];
  endtask

  task automatic test_reset();
    @(negedge clk_cpu);
    drive(0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0);
    reset = 1'b1;
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b expected 0", busy); end
    n_cmp++; if (gnt !== 2'b00) begin n_err++; $display("FAIL rst_gnt: got %b expected 00", gnt); end
    n_cmp++; if (mem_we !== 1'b0) begin n_err++; $display("FAIL rst_mem_we: got %b expected 0", mem_we); end
    n_cmp++; if ({m0_ack, m1_ack} !== 2'b00) begin n_err++; $display("FAIL rst_acks: got %b expected 00", {m0_ack, m1_ack}); end
    n_cmp++; if (mem_addr !== '0) begin n_err++; $display("FAIL rst_mem_addr: got %h expected 0", mem_addr); end
    n_cmp++; if (mem_din !== '0) begin n_err++; $display("FAIL rst_mem_din: got %h expected 0", mem_din); end
    n_cmp++; if (m0_rdata !== '0) begin n_err++; $display("FAIL rst_m0_rdata: got %h expected 0", m0_rdata); end
    n_cmp++; if (m1_rdata !== '0) begin n_err++; $display("FAIL rst_m1_rdata: got %h expected 0", m1_rdata); end
    @(negedge clk_cpu);
    reset = 1'b0;
    rd_ref[0] = '0; rd_ref[1] = '0;
    last_ref = 1'b1; addr_ref = '0; din_ref = '0;
  endtask

  task automatic test_write();
    clear_q();
    push(0, 1'b1, 12'h010, 32'hDEADBEEF);
    run_scenario(0);
    n_cmp++; if (mem[12'h010] !== 32'hDEADBEEF) begin n_err++; $display("FAIL write_mem: got %h expected deadbeef", mem[12'h010]); end
  endtask

  task automatic test_read();
    clear_q();
    push(0, 1'b0, 12'h010, 32'h0);
    run_scenario(0);
    n_cmp++; if (m0_rdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL read_m0_rdata: got %h expected deadbeef", m0_rdata); end
    n_cmp++; if (m1_rdata !== 32'h0) begin n_err++; $display("FAIL read_m1_rdata: got %h expected 0", m1_rdata); end
  endtask

  task automatic test_prefill();
    clear_q();
    for (int k = 0; k < 8; k++) push(0, 1'b1, 12'(12'h100 + k), $urandom);
    for (int k = 8; k < 16; k++) push(1, 1'b1, 12'(12'h100 + k), $urandom);
    push(0, 1'b1, 12'h004, 32'hA5A50004);
    push(1, 1'b1, 12'h020, 32'h5A5A0020);
    run_scenario(0);
    n_cmp++; if (mem[12'h020] !== 32'h5A5A0020) begin n_err++; $display("FAIL prefill_mem: got %h expected 5a5a0020", mem[12'h020]); end
  endtask

  task automatic test_tie();
    clear_q();
    push(0, 1'b0, 12'h004, 32'h0);
    push(1, 1'b1, 12'h008, 32'h12345678);
    run_scenario(0);
    n_cmp++; if (m0_rdata !== 32'hA5A50004) begin n_err++; $display("FAIL tie_m0_rdata: got %h expected a5a50004", m0_rdata); end
    n_cmp++; if (mem[12'h008] !== 32'h12345678) begin n_err++; $display("FAIL tie_mem: got %h expected 12345678", mem[12'h008]); end
  endtask

  task automatic test_alternation();
    clear_q();
    for (int k = 0; k < 3; k++) begin
      push(0, 1'($urandom_range(0, 1)), 12'(12'h100 + $urandom_range(0, 15)), $urandom);
      push(1, 1'($urandom_range(0, 1)), 12'(12'h100 + $urandom_range(0, 15)), $urandom);
    end
    run_scenario(0);
    n_cmp++; if ({m0_req, m1_req} !== 2'b00 || busy !== 1'b1) begin n_err++; $display("FAIL alt_end: got req %b busy %b expected 00/1", {m0_req, m1_req}, busy); end
  endtask

  task automatic test_addr_change();
    clear_q();
    push(1, 1'b0, 12'h020, 32'h0);
    run_scenario(1);
    n_cmp++; if (m1_rdata !== 32'h5A5A0020) begin n_err++; $display("FAIL addr_change_rdata: got %h expected 5a5a0020", m1_rdata); end
  endtask

  task automatic test_random();
    int n0, n1;
    for (int r = 0; r < 20; r++) begin
      clear_q();
      n0 = $urandom_range(0, 3);
      n1 = $urandom_range(0, 3);
      if (n0 == 0 && n1 == 0) n0 = 1;
      for (int k = 0; k < n0; k++) push(0, 1'($urandom_range(0, 1)), 12'(12'h100 + $urandom_range(0, 15)), $urandom);
      for (int k = 0; k < n1; k++) push(1, 1'($urandom_range(0, 1)), 12'(12'h100 + $urandom_range(0, 15)), $urandom);
      run_scenario(int'($urandom_range(0, 2)));
    end
  endtask

  task automatic test_reset_abort();
    logic [DW-1:0] d;
    d = $urandom;
    @(negedge clk_cpu);
    drive(1, 1'b1, 1'b0, 12'h010, d);
    @(negedge clk_cpu);
    @(negedge clk_cpu);
    n_cmp++; if (gnt !== 2'b10 || busy !== 1'b1) begin n_err++; $display("FAIL abort_pre: got gnt %b busy %b expected 10/1", gnt, busy); end
    reset = 1'b1;
    #1;
    n_cmp++; if (mem_we !== 1'b0) begin n_err++; $display("FAIL abort_mem_we: got %b expected 0", mem_we); end
    n_cmp++; if (gnt !== 2'b00) begin n_err++; $display("FAIL abort_gnt: got %b expected 00", gnt); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL abort_busy: got %b expected 0", busy); end
    n_cmp++; if (m1_rdata !== '0) begin n_err++; $display("FAIL abort_rdata: got %h expected 0", m1_rdata); end
    rd_ref[0] = '0; rd_ref[1] = '0;
    repeat (2) begin
      @(negedge clk_cpu);
      n_cmp++; if (m1_ack !== 1'b0 || mem_we !== 1'b0) begin n_err++; $display("FAIL abort_hold: got ack %b we %b expected 0/0", m1_ack, mem_we); end
    end
    reset = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk_cpu);
      n_cmp++; if (m1_ack !== (c == 3)) begin n_err++; $display("FAIL reissue_ack cyc %0d: got %b expected %b", c, m1_ack, c == 3); end
      n_cmp++; if (gnt !== 2'b10) begin n_err++; $display("FAIL reissue_gnt cyc %0d: got %b expected 10", c, gnt); end
      n_cmp++; if (mem_we !== 1'b0) begin n_err++; $display("FAIL reissue_we cyc %0d: got %b expected 0", c, mem_we); end
      if (c == 3) begin
        n_cmp++; if (m1_rdata !== ref_mem[12'h010]) begin n_err++; $display("FAIL reissue_rdata: got %h expected %h", m1_rdata, ref_mem[12'h010]); end
        drive(1, 1'b0, 1'b0, '0, '0);
      end
    end
    last_ref = 1'b1; addr_ref = 12'h010; din_ref = d;
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_prefill();
    test_reset();
    test_tie();
    test_alternation();
    test_addr_change();
    test_random();
    test_reset_abort();
    @(negedge clk_cpu);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
